pkt_fifo: RTL
=============

Name: pkt_fifo

Overview:
Single-clock, store-and-forward packet FIFO; next generation of the ingress packet buffer.
- Generalised in data width and depth.
- Adds write back-pressure, packet commit/rollback, and a first-word-fall-through valid/ready read port.
- Sits between the ingress framing logic (sop/eop/vld beats) and the SRAM write scheduler.
- A packet becomes visible to the reader only after its eop beat is stored.

Parameters:
fifo_data_width, 64, payload bits per beat
fifo_length, 32, entries; power of two, >= 4
fifo_pointer_width, 5, log2(fifo_length); pointers carry one extra wrap bit internally
fifo_cnt_width, 16, width of drop_cnt

Ports:
clk  input  1  single clock for both sides
rst  input  1  asynchronous, active-high reset
wr_vld  input  1  write beat valid
wr_sop  input  1  first beat of packet (qualified by wr_vld)
wr_eop  input  1  last beat of packet (qualified by wr_vld)
wr_data  input  fifo_data_width  write payload
wr_ready  output  1  beat accepted when wr_vld & wr_ready
rd_ready  input  1  consumer takes head beat
rd_vld  output  1  head beat valid (committed data present)
rd_sop  output  1  head beat is first of packet
rd_eop  output  1  head beat is last of packet
rd_data  output  fifo_data_width  head beat payload
pkt_cnt  output  fifo_pointer_width+1  committed packets held
level  output  fifo_pointer_width+1  entries used, including uncommitted beats
overflow  output  1  sticky; a packet was dropped
proto_err  output  1  sticky; framing violation seen
drop_cnt  output  fifo_cnt_width  packets dropped; saturating

Behaviour:
- Reset (async, rst=1): wptr, cptr (commit pointer) and rptr = 0; state = IDLE; pkt_cnt, level, drop_cnt = 0; overflow, proto_err, rd_vld = 0; wr_ready = 1. Memory contents are not cleared.
- Reset mid-packet: the partial packet is lost and no counters are kept.
- Entry format: {sop, eop, data}.
- Full condition: (wptr - rptr) == fifo_length. wr_ready = !full, except in DISCARD, where wr_ready = 1.
- Write FSM:
  - IDLE: accepted beat with sop stores the beat and goes to PKT. If that beat also has eop, the packet commits immediately and the FSM stays in IDLE. An accepted beat without sop is discarded and sets proto_err.
  - PKT: each accepted beat is stored and wptr increments. An eop beat sets cptr <= wptr+1 (commit), pkt_cnt increments and the FSM goes to IDLE. A sop beat here aborts the current packet: wptr <= cptr, proto_err set, the new packet starts (still PKT).
  - Oversize guard, PKT: full while pkt_cnt == 0 and rptr == cptr (the packet alone fills the FIFO) → wptr <= cptr, overflow = 1, drop_cnt += 1, go to DISCARD.
  - DISCARD: all beats are accepted and dropped; an eop beat goes to IDLE. A sop beat here goes to PKT (new packet) and sets proto_err.
- Read side:
  - rd_vld = (pkt_cnt != 0); rd_* driven combinationally from mem[rptr] (zero-latency show-ahead).
  - Pop on rd_vld & rd_ready: rptr increments. If the popped beat has eop, pkt_cnt decrements.
  - Reads never advance past cptr.
- Same-cycle commit and eop pop: pkt_cnt unchanged.
- level = wptr - rptr, updated in the same cycle as the pointers.
- Wrap-around: pointers are fifo_pointer_width+1 bits and modular. Rollback and compare use the same modular arithmetic.
- Latency: a committed eop beat is visible on rd_vld in the next cycle.
- drop_cnt saturates at all ones.

Optional Feature:
PKT_FIFO_DROP_EN
- Defined: wr_ready is tied to 1 and the FIFO never back-pressures. Any accepted beat arriving when full triggers rollback to cptr, overflow=1, drop_cnt+1 and DISCARD until eop. Committed packets are never affected.
- Undefined: back-pressure as above; drops occur only via the oversize guard.

Decomposition:
- Shared package/header pkt_fifo_pkg:
  - FSM encodings IDLE/PKT/DISCARD (2 bits)
  - entry bit positions (SOP_BIT, EOP_BIT)
  - entry width = fifo_data_width+2
- One sub-module: pkt_fifo_mem, a 1W1R register array with synchronous write and asynchronous read, parametrised by width and depth. Pointer and FSM logic stay in pkt_fifo.

Test Plan:
All scenarios use fifo_length=8, fifo_data_width=64.
- Three packets of 2, 1 (sop&eop) and 3 beats, data 0x10..0x15, rd_ready=1 → rd_vld rises one cycle after each eop. Output order is 0x10..0x15 with correct sop/eop. pkt_cnt peaks at ≤3. level returns to 0.
- Write a 5-beat packet with rd_ready=0 → rd_vld stays 0 until the eop beat is stored. level=5, pkt_cnt=1.
- Committed 6-beat packet, then a 4-beat packet, rd_ready=0 → wr_ready falls after 2 beats of the second packet (level=8). Raising rd_ready drains the first packet; the second packet completes and level ends at 4.
- 10-beat packet with an empty FIFO → after 8 beats: overflow=1, drop_cnt=1, level=0, DISCARD. The remaining beats are accepted; the next packet is stored normally.
- sop at beat 3 of an open packet, and a non-sop beat in IDLE → proto_err=1. Only the restarted packet is output. The stray beat is absent.
- Assert rst mid-packet with level=5 → all outputs return to reset values immediately, independent of clk. A following 2-beat packet passes intact.

Source files
------------

// File: rtl/pkt_fifo_pkg.sv
// Shared types and entry layout for the store-and-forward packet FIFO.
package pkt_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PKT     = 2'd1,
      DISCARD = 2'd2
   } wr_state_t;

   // Entry layout is {sop, eop, data}; flag positions sit just above the payload.
   localparam int unsigned SOP_OFS = 1;
   localparam int unsigned EOP_OFS = 0;

   function automatic int unsigned entry_width(input int unsigned data_width);
      return data_width + 2;
   endfunction

   function automatic int unsigned sop_bit(input int unsigned data_width);
      return data_width + SOP_OFS;
   endfunction

   function automatic int unsigned eop_bit(input int unsigned data_width);
      return data_width + EOP_OFS;
   endfunction

endpackage

// File: rtl/pkt_fifo_mem.sv
// 1W1R register array: synchronous write, asynchronous (show-ahead) read.
module pkt_fifo_mem #(
   parameter int unsigned width = 66,
   parameter int unsigned depth = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(depth)-1:0] waddr,
   input  logic [width-1:0]         wdata,
   input  logic [$clog2(depth)-1:0] raddr,
   output logic [width-1:0]         rdata
);

   logic [width-1:0] mem [depth];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_fifo.sv
// Store-and-forward packet FIFO with commit/rollback and FWFT read port.
// Define PKT_FIFO_DROP_EN to drop packets on full instead of back-pressuring.
module pkt_fifo
   import pkt_fifo_pkg::*;
#(
   parameter int unsigned fifo_data_width    = 64,
   parameter int unsigned fifo_length        = 32,
   parameter int unsigned fifo_pointer_width = 5,
   parameter int unsigned fifo_cnt_width     = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_vld,
   input  logic                          wr_sop,
   input  logic                          wr_eop,
   input  logic [fifo_data_width-1:0]    wr_data,
   output logic                          wr_ready,
   input  logic                          rd_ready,
   output logic                          rd_vld,
   output logic                          rd_sop,
   output logic                          rd_eop,
   output logic [fifo_data_width-1:0]    rd_data,
   output logic [fifo_pointer_width:0]   pkt_cnt,
   output logic [fifo_pointer_width:0]   level,
   output logic                          overflow,
   output logic                          proto_err,
   output logic [fifo_cnt_width-1:0]     drop_cnt
);

   localparam int unsigned PW      = fifo_pointer_width;
   localparam int unsigned CW      = fifo_cnt_width;
   localparam int unsigned EW      = entry_width(fifo_data_width);
   localparam int unsigned SOP_BIT = sop_bit(fifo_data_width);
   localparam int unsigned EOP_BIT = eop_bit(fifo_data_width);
   localparam logic [PW:0] PTR_ONE = (PW+1)'(1);
   localparam logic [PW:0] PTR_LEN = (PW+1)'(fifo_length);

   wr_state_t   state, state_nxt;
   logic [PW:0] wptr, cptr, rptr;
   logic [PW:0] wptr_nxt, cptr_nxt, rptr_nxt, wr_base;
   logic        full, accept, pop, pop_eop;
   logic        store, we, commit, drop, perr;
   logic        oversize, drop_full;
   logic [EW-1:0] rd_entry;

   assign full    = (wptr - rptr) == PTR_LEN;
   assign accept  = wr_vld && wr_ready;
   assign rd_vld  = (pkt_cnt != '0);
   assign pop     = rd_vld && rd_ready;
   assign pop_eop = pop && rd_entry[EOP_BIT];
   assign rptr_nxt = pop ? rptr + PTR_ONE : rptr;

`ifdef PKT_FIFO_DROP_EN
   assign wr_ready  = 1'b1;
   assign oversize  = 1'b0;
   assign drop_full = full;
`else
   assign wr_ready  = (state == DISCARD) || !full;
   assign oversize  = full && (pkt_cnt == '0) && (rptr == cptr);
   assign drop_full = 1'b0;
`endif

   // A sop inside an open packet restarts at the commit point; otherwise append.
   assign wr_base = (state == PKT && !wr_sop) ? wptr : cptr;

   // Write FSM next-state, pointer updates and event strobes.
   always_comb begin
      state_nxt = state;
      wptr_nxt  = wptr;
      cptr_nxt  = cptr;
      store     = 1'b0;
      we        = 1'b0;
      commit    = 1'b0;
      drop      = 1'b0;
      perr      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!wr_sop) begin
                  perr = 1'b1;
               end else if (drop_full) begin
                  drop      = 1'b1;
                  state_nxt = wr_eop ? IDLE : DISCARD;
               end else begin
                  store = 1'b1;
               end
            end
         end
         PKT: begin
            if (oversize) begin
               wptr_nxt  = cptr;
               drop      = 1'b1;
               state_nxt = DISCARD;
            end else if (accept) begin
               perr = wr_sop;
               if (drop_full) begin
                  wptr_nxt  = cptr;
                  drop      = 1'b1;
                  state_nxt = wr_eop ? IDLE : DISCARD;
               end else begin
                  store = 1'b1;
               end
            end
         end
         DISCARD: begin
            if (accept) begin
               if (wr_sop) begin
                  perr = 1'b1;
                  if (full) begin
                     drop      = 1'b1;
                     state_nxt = wr_eop ? IDLE : DISCARD;
                  end else begin
                     store = 1'b1;
                  end
               end else if (wr_eop) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (store) begin
         we       = 1'b1;
         wptr_nxt = wr_base + PTR_ONE;
         if (wr_eop) begin
            cptr_nxt  = wr_base + PTR_ONE;
            commit    = 1'b1;
            state_nxt = IDLE;
         end else begin
            state_nxt = PKT;
         end
      end
   end

   // State and pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         wptr  <= '0;
         cptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         state <= state_nxt;
         wptr  <= wptr_nxt;
         cptr  <= cptr_nxt;
         rptr  <= rptr_nxt;
         level <= wptr_nxt - rptr_nxt;
      end
   end

   // Packet count and sticky status; a same-cycle commit and eop pop cancel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_cnt   <= '0;
         overflow  <= 1'b0;
         proto_err <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         case ({commit, pop_eop})
            2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
            2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
            default: pkt_cnt <= pkt_cnt;
         endcase
         if (drop) overflow <= 1'b1;
         if (perr) proto_err <= 1'b1;
         if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CW'(1);
      end
   end

   pkt_fifo_mem #(
      .width (EW),
      .depth (fifo_length)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (wr_base[PW-1:0]),
      .wdata ({wr_sop, wr_eop, wr_data}),
      .raddr (rptr[PW-1:0]),
      .rdata (rd_entry)
   );

   assign rd_sop  = rd_entry[SOP_BIT];
   assign rd_eop  = rd_entry[EOP_BIT];
   assign rd_data = rd_entry[fifo_data_width-1:0];

endmodule
